pattern_frame_tx: RTL

- Transmit-side counterpart of the serial pattern detector.
- Captures a parallel payload word on a start request and emits a serial frame: the fixed sync pattern (default 11010), then the payload MSB first, with an optional parity bit.
- Qualifies each bit with a valid/ready handshake, so its output can drive the detector's data/valid inputs directly.
- Sits between a control sequencer and the serial link.

---
 rtl/pattern_frame_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_frame_tx.sv
// pattern_frame_tx: serialises a captured payload word behind a fixed sync
// pattern, one bit per valid/ready beat, followed by an optional idle gap.
// Optional build macro PATTERN_FRAME_TX_PARITY_EN appends an even-parity bit
// after the payload; without it the frame is sync pattern plus payload only.
module pattern_frame_tx #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11010,
  parameter int               DATA_W  = 8,
  parameter int               GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int FW    = PAT_W + DATA_W;
  localparam int CMAX  = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CNT_W-1:0] PAT_LOAD  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAYLOAD,
`ifdef PATTERN_FRAME_TX_PARITY_EN
    PARITY,
`endif
    GAP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [FW-1:0]    sreg, sreg_n, shifted;
  logic             data_n, valid_n, busy_n, done_n;
  logic             beat, last_beat;
`ifdef PATTERN_FRAME_TX_PARITY_EN
  logic             par, par_n;
`endif

  // The sync pattern and payload share one shift register so both leave MSB first.
  assign shifted = sreg << 1;
  assign beat    = valid_o & ready_i;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      sreg    <= '0;
      data_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef PATTERN_FRAME_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gap_cnt <= gap_n;
      sreg    <= sreg_n;
      data_o  <= data_n;
      valid_o <= valid_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
`ifdef PATTERN_FRAME_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Next-state and next-output logic; everything holds unless a beat or start moves it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_n     = gap_cnt;
    sreg_n    = sreg;
    data_n    = data_o;
    valid_n   = valid_o;
    busy_n    = busy_o;
    done_n    = 1'b0;
    last_beat = 1'b0;
`ifdef PATTERN_FRAME_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        data_n  = 1'b0;
        if (start_i) begin
          sreg_n  = {PATTERN, data_i};
          cnt_n   = PAT_LOAD;
          state_n = SYNC;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          data_n  = PATTERN[PAT_W-1];
`ifdef PATTERN_FRAME_TX_PARITY_EN
          par_n   = ^data_i;
`endif
        end
      end
      SYNC: begin
        if (beat) begin
          sreg_n = shifted;
          data_n = shifted[FW-1];
          if (cnt == '0) begin
            cnt_n   = DATA_LOAD;
            state_n = PAYLOAD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (beat) begin
          sreg_n = shifted;
          if (cnt == '0) begin
`ifdef PATTERN_FRAME_TX_PARITY_EN
            state_n = PARITY;
            data_n  = par;
`else
            last_beat = 1'b1;
`endif
          end else begin
            cnt_n  = cnt - 1'b1;
            data_n = shifted[FW-1];
          end
        end
      end
`ifdef PATTERN_FRAME_TX_PARITY_EN
      PARITY: begin
        if (beat) begin
          last_beat = 1'b1;
        end
      end
`endif
      GAP: begin
        valid_n = 1'b0;
        busy_n  = 1'b1;
        if (gap_cnt == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    if (last_beat) begin
      valid_n = 1'b0;
      data_n  = 1'b0;
      done_n  = 1'b1;
      sreg_n  = '0;
      if (GAP_CYC > 0) begin
        state_n = GAP;
        gap_n   = GAP_LOAD;
        busy_n  = 1'b1;
      end else begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    end
  end

endmodule
